// File: rtl/ship_input_scheduler.sv
// ship_input_scheduler: debounced buttons to one-cycle ship move and laser fire commands
module ship_input_scheduler #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int MOVE_PERIOD     = 2,
  parameter int COOLDOWN_FRAMES = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_fire,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic [9:0] gun_position,
  input  logic       laser_active,
  output logic       move_left,
  output logic       move_right,
  output logic       fire,
  output logic [9:0] fire_x,
  output logic       busy
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int MW = $clog2(MOVE_PERIOD + 1);
  localparam int CW = COOLDOWN_FRAMES > 0 ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [MW-1:0] MV_LAST = MW'(MOVE_PERIOD - 1);
  localparam logic [CW-1:0] CD_LAST = CW'(COOLDOWN_FRAMES - 1);
  typedef enum logic [1:0] {IDLE, FIRE, FLIGHT, COOLDOWN} state_t;
  logic [2:0] raw, sync1_q, sync2_q, db_q, db_d;
  logic [DW-1:0] db_cnt_q [3];
  logic [DW-1:0] db_cnt_d [3];
  logic [MW-1:0] mv_cnt_q, mv_cnt_d;
  logic [CW-1:0] cd_cnt_q, cd_cnt_d;
  logic [9:0] fire_x_q, fire_x_d;
  logic move_left_q, move_left_d, move_right_q, move_right_d;
  logic fire_prev_q, first_q, first_d;
  logic dir_l, dir_r, rise;
  state_t state_q, state_d;
  assign raw = {btn_fire, btn_right, btn_left};
  // two-flop synchroniser per button; bit 0 left, 1 right, 2 fire
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end
  // debouncer: flip the stable value once the input has disagreed DEBOUNCE_CYCLES cycles in a row
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) db_d[i] = sync2_q[i];
        else db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end
  // debouncer state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      db_q <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      db_q <= db_d;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end
  assign dir_l = enable & db_q[0] & ~db_q[1];
  assign dir_r = enable & db_q[1] & ~db_q[0];
  // move scheduler: idle counter parks at its last value so a fresh press steps on the next tick
  always_comb begin
    mv_cnt_d = !(dir_l | dir_r) ? MV_LAST :
               !frame_tick ? mv_cnt_q :
               mv_cnt_q == MV_LAST ? '0 : mv_cnt_q + 1'b1;
    move_left_d  = dir_l & frame_tick & (mv_cnt_q == MV_LAST);
    move_right_d = dir_r & frame_tick & (mv_cnt_q == MV_LAST);
  end
  // move scheduler registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mv_cnt_q     <= MV_LAST;
      move_left_q  <= 1'b0;
      move_right_q <= 1'b0;
    end else begin
      mv_cnt_q     <= mv_cnt_d;
      move_left_q  <= move_left_d;
      move_right_q <= move_right_d;
    end
  end
  assign rise = db_q[2] & ~fire_prev_q;
  // fire sequencer next state; the laser block is a cycle late, so the first FLIGHT cycle ignores it
  always_comb begin
    state_d  = state_q;
    first_d  = state_q == FIRE;
    fire_x_d = state_q == FIRE ? gun_position : fire_x_q;
    cd_cnt_d = state_q == COOLDOWN && frame_tick ? cd_cnt_q + 1'b1 :
               state_q == COOLDOWN ? cd_cnt_q : '0;
    case (state_q)
      IDLE:     state_d = rise && enable ? FIRE : IDLE;
      FIRE:     state_d = FLIGHT;
      FLIGHT:   state_d = !first_q && !laser_active ? COOLDOWN : FLIGHT;
      COOLDOWN: state_d = COOLDOWN_FRAMES == 0 || (frame_tick && cd_cnt_q == CD_LAST) ? IDLE : COOLDOWN;
      default:  state_d = IDLE;
    endcase
  end
  // fire sequencer registers; the edge detector tracks the button in every state so holds never repeat
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      first_q     <= 1'b0;
      fire_prev_q <= 1'b0;
      fire_x_q    <= '0;
      cd_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      first_q     <= first_d;
      fire_prev_q <= db_q[2];
      fire_x_q    <= fire_x_d;
      cd_cnt_q    <= cd_cnt_d;
    end
  end
  assign move_left  = move_left_q;
  assign move_right = move_right_q;
  assign fire       = state_q == FIRE;
  assign fire_x     = fire ? gun_position : fire_x_q;
  assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_ship_input_scheduler.sv
// tb_ship_input_scheduler: directed stimulus with a scoreboard of expected command pulses
module tb_ship_input_scheduler;
  logic clk = 1'b0;
  logic reset, btn_left, btn_right, btn_fire, enable, laser_active;
  logic frame_tick = 1'b0;
  logic [9:0] gun_position;
  logic move_left, move_right, fire, busy;
  logic [9:0] fire_x;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  typedef struct {int kind; int cyc; int x;} ev_t;
  ev_t sb[$];
  localparam int ML = 0, MR = 1, FI = 2;

  ship_input_scheduler #(.DEBOUNCE_CYCLES(4), .MOVE_PERIOD(2), .COOLDOWN_FRAMES(3)) dut (
    .clk(clk), .reset(reset), .btn_left(btn_left), .btn_right(btn_right), .btn_fire(btn_fire),
    .frame_tick(frame_tick), .enable(enable), .gun_position(gun_position), .laser_active(laser_active),
    .move_left(move_left), .move_right(move_right), .fire(fire), .fire_x(fire_x), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) frame_tick = ((cyc + 1) % 20) == 0;

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(int kind, int c, int x);
    ev_t e;
    e.kind = kind;
    e.cyc = c;
    e.x = x;
    sb.push_back(e);
  endtask

  task automatic pop(int kind);
    ev_t e;
    if (sb.size() == 0) begin
      check("unexpected_pulse_kind", kind, -1);
    end else begin
      e = sb.pop_front();
      check("pulse_kind", kind, e.kind);
      check("pulse_cycle", cyc, e.cyc);
      if (kind == FI) check("fire_x_at_fire", int'(fire_x), e.x);
    end
  endtask

  task automatic at(int n);
    while (cyc < n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (move_left && move_right) check("move_exclusive", 1, 0);
    if (move_left) pop(ML);
    if (move_right) pop(MR);
    if (fire) pop(FI);
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; btn_left = 1'b0; btn_right = 1'b0; btn_fire = 1'b0;
    enable = 1'b1; laser_active = 1'b0; gun_position = 10'd320;
    at(2);
    check("rst_move_left", int'(move_left), 0);
    check("rst_move_right", int'(move_right), 0);
    check("rst_fire", int'(fire), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_fire_x", int'(fire_x), 0);
    at(3); reset = 1'b0;
    at(10); btn_left = 1'b1;
    at(13); btn_left = 1'b0;
    at(30); btn_left = 1'b1;
    push(ML, 40, 0); push(ML, 80, 0); push(ML, 120, 0);
    at(130); btn_left = 1'b0;
    at(150); btn_left = 1'b1; btn_right = 1'b1;
    at(190); btn_right = 1'b0;
    push(ML, 200, 0);
    at(205); btn_left = 1'b0;
    at(230); btn_fire = 1'b1;
    push(FI, 237, 320);
    at(237); check("busy_in_fire", int'(busy), 1);
    at(238); gun_position = 10'd100; laser_active = 1'b1;
    at(245); btn_fire = 1'b0;
    at(250); check("fire_x_held", int'(fire_x), 320);
    check("busy_in_flight", int'(busy), 1);
    at(260); btn_fire = 1'b1;
    at(270); btn_fire = 1'b0;
    at(278); laser_active = 1'b0;
    at(300); btn_fire = 1'b1;
    at(319); check("busy_before_cd_end", int'(busy), 1);
    at(320); check("busy_after_cd_end", int'(busy), 0);
    at(340); btn_fire = 1'b0;
    at(350); btn_fire = 1'b1;
    push(FI, 357, 100);
    at(358); laser_active = 1'b1;
    at(360); btn_fire = 1'b0;
    at(370);
    check("busy_mid_shot", int'(busy), 1);
    check("fire_x_mid_shot", int'(fire_x), 100);
    reset = 1'b1;
    at(371);
    reset = 1'b0; laser_active = 1'b0;
    check("busy_after_reset", int'(busy), 0);
    check("fire_x_after_reset", int'(fire_x), 0);
    at(380); enable = 1'b0; btn_left = 1'b1; btn_fire = 1'b1;
    at(410); btn_fire = 1'b0;
    at(420); gun_position = 10'd77;
    at(430); enable = 1'b1;
    at(433); btn_fire = 1'b1;
    push(ML, 440, 0); push(FI, 440, 77);
    at(445); btn_left = 1'b0; btn_fire = 1'b0;
    at(499); check("busy_before_cd_end2", int'(busy), 1);
    at(500); check("busy_after_cd_end2", int'(busy), 0);
    at(510); check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
